// File: rtl/space_invaders_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : space_invaders_pkg
//  Description : Shared game types and constants. Holds the bomb FSM state
//                type, the bomb sprite geometry/bitmap and the LFSR taps
//                used by the enemy projectile.
//  Revision    : 1.0 - initial release
// ============================================================================
package space_invaders_pkg;

    typedef enum logic [1:0] {
        COOL = 2'd0,
        SEL  = 2'd1,
        FALL = 2'd2
    } bomb_state_t;

    // Image source the bitmap below was converted from.
    localparam string BOMB_FILE   = "./sprites/bomb.mem";
    localparam int    BOMB_WIDTH  = 3;
    localparam int    BOMB_HEIGHT = 4;
    localparam int    BOMB_SCALE  = 4;

    // Row-major, bit (row*BOMB_WIDTH + col); rows top to bottom.
    localparam logic [BOMB_WIDTH*BOMB_HEIGHT-1:0] BOMB_BITMAP = 12'b010_111_111_010;
    localparam int    BOMB_COLR   = 12;

    localparam logic [15:0] BOMB_LFSR_TAPS = 16'hB400;

endpackage : space_invaders_pkg
`default_nettype wire

// File: rtl/galois_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : galois_lfsr16
//  Description : 16-bit right-shifting Galois LFSR. Advances one step on each
//                cycle with step=1; loads seed on reset.
//  Ports       : clk, rst (async, active-low), step, seed[15:0] -> q[15:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module galois_lfsr16 #(
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic [15:0] seed,   // tie to a constant: it is the async load value
    output logic [15:0] q
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= seed;
        end else if (step) begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
        end
    end

    assign q = lfsr_q;

endmodule : galois_lfsr16
`default_nettype wire

// File: rtl/sprite.sv
`default_nettype none
// ============================================================================
//  Module      : sprite
//  Description : Scaled 1-bpp bitmap sprite. The row is resolved once per line
//                (on line), the column per pixel; outputs are registered, so
//                drawing/pix lag the beam position by one clock.
//  Ports       : clk, rst (async, active-low), en, line, sx/sy (beam),
//                sprx/spry (sprite origin) -> pix, drawing
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite #(
    parameter int                           CORDW     = 16,
    parameter int                           COLR_BITS = 4,
    parameter int                           H_RES     = 640,
    parameter int                           WIDTH     = 3,
    parameter int                           HEIGHT    = 4,
    parameter int                           SCALE     = 4,
    parameter logic [WIDTH*HEIGHT-1:0]      BITMAP    = '0,
    parameter logic [COLR_BITS-1:0]         COLR      = '1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        line,
    input  logic signed [CORDW-1:0]     sx,
    input  logic signed [CORDW-1:0]     sy,
    input  logic signed [CORDW-1:0]     sprx,
    input  logic signed [CORDW-1:0]     spry,
    output logic [COLR_BITS-1:0]        pix,
    output logic                        drawing
);

    localparam int SHW = $clog2(SCALE);             // SCALE is a power of two
    localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int IW  = $clog2(WIDTH*HEIGHT);
    localparam logic [CORDW-1:0] SPAN_X  = CORDW'(WIDTH*SCALE);
    localparam logic [CORDW-1:0] SPAN_Y  = CORDW'(HEIGHT*SCALE);
    localparam logic [CORDW-1:0] H_LIMIT = CORDW'(H_RES);

    logic signed [CORDW-1:0] w_dx, w_dy;
    logic                    w_row_in, w_col_in, w_set;
    logic [CW-1:0]           w_col;
    logic [IW-1:0]           w_idx;

    logic                    row_ok_q;
    logic [RW-1:0]           row_q;
    logic                    drawing_q;
    logic [COLR_BITS-1:0]    pix_q;

    assign w_dy = sy - spry;
    assign w_dx = sx - sprx;
    // Unsigned compare rejects negative offsets as well as ones past the span.
    assign w_row_in = en && ($unsigned(w_dy) < SPAN_Y);
    // Clip at the right edge of the active area so blanking stays clean.
    assign w_col_in = row_ok_q && ($unsigned(w_dx) < SPAN_X) && ($unsigned(sx) < H_LIMIT);
    assign w_col    = w_dx[SHW +: CW];
    assign w_idx    = IW'(row_q) * IW'(WIDTH) + IW'(w_col);
    assign w_set    = en && w_col_in && BITMAP[w_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_ok_q  <= 1'b0;
            row_q     <= '0;
            drawing_q <= 1'b0;
            pix_q     <= '0;
        end else begin
            if (line) begin
                row_ok_q <= w_row_in;
                row_q    <= w_dy[SHW +: RW];
            end
            drawing_q <= w_set;
            pix_q     <= w_set ? COLR : '0;
        end
    end

    assign drawing = drawing_q;
    assign pix     = pix_q;

endmodule : sprite
`default_nettype wire

// File: rtl/alien_bomb.sv
`default_nettype none
// ============================================================================
//  Module      : alien_bomb
//  Description : Enemy bomb. After a random cooldown it asks the alien grid for
//                a shooter column, spawns under the returned alien, falls a
//                fixed step per frame and retires off-screen or on hit.
//  Ports       : clk, rst (async, active-low), frame, screen_line, en, speed,
//                hit, screen_x/_y; grid handshake sel_req/sel_col/sel_ack/
//                sel_hit/sel_x/sel_y; outputs bomb_x/_y, bomb_active,
//                drawing, pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module alien_bomb
    import space_invaders_pkg::*;
#(
    parameter int          SCREEN_CORDW = 16,
    parameter int          COLR_BITS    = 4,
    parameter int          H_RES        = 640,
    parameter int          V_RES        = 480,
    parameter int          N_COLS       = 8,
    parameter int          COOLDOWN_MIN = 30,
    parameter int          SPAWN_DX     = 16,
    parameter int          SPAWN_DY     = 24,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                frame,
    input  logic                                screen_line,
    input  logic                                en,
    input  logic [7:0]                          speed,
    input  logic                                hit,
    input  logic signed [SCREEN_CORDW-1:0]      screen_x,
    input  logic signed [SCREEN_CORDW-1:0]      screen_y,
    output logic                                sel_req,
    output logic [$clog2(N_COLS)-1:0]           sel_col,
    input  logic                                sel_ack,
    input  logic                                sel_hit,
    input  logic signed [SCREEN_CORDW-1:0]      sel_x,
    input  logic signed [SCREEN_CORDW-1:0]      sel_y,
    output logic signed [SCREEN_CORDW-1:0]      bomb_x,
    output logic signed [SCREEN_CORDW-1:0]      bomb_y,
    output logic                                bomb_active,
    output logic                                drawing,
    output logic [COLR_BITS-1:0]                pixel
);

    localparam int COLW = $clog2(N_COLS);
    localparam int CDW  = $clog2(COOLDOWN_MIN + 16);   // holds COOLDOWN_MIN + 15
    localparam logic signed [SCREEN_CORDW-1:0] V_LIMIT = SCREEN_CORDW'(V_RES);

    bomb_state_t                    state_q, state_d;
    logic [CDW-1:0]                 cool_q, cool_d;
    logic [COLW-1:0]                tries_q, tries_d;
    logic [COLW-1:0]                sel_col_q, sel_col_d;
    logic                           sel_req_q, sel_req_d;
    logic                           gap_q, gap_d;      // one-cycle request gap after a miss
    logic signed [SCREEN_CORDW-1:0] bomb_x_q, bomb_x_d;
    logic signed [SCREEN_CORDW-1:0] bomb_y_q, bomb_y_d;

    logic [15:0]                    w_lfsr;
    logic [7:0]                     w_unused_lfsr;
    logic [COLW-1:0]                w_rand_col, w_next_col;
    logic signed [SCREEN_CORDW-1:0] w_ny;
    logic                           w_active;
    logic                           w_spr_drawing;
    logic [COLR_BITS-1:0]           w_spr_pix;

    galois_lfsr16 #(
        .TAPS (BOMB_LFSR_TAPS)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (frame),
        .seed (LFSR_SEED),
        .q    (w_lfsr)
    );

    assign w_unused_lfsr = w_lfsr[15:8];
    assign w_rand_col    = COLW'({1'b0, w_lfsr[3:0]} % 5'(N_COLS));
    assign w_next_col    = (sel_col_q == COLW'(N_COLS - 1)) ? '0 : sel_col_q + 1'b1;
    assign w_ny          = bomb_y_q + SCREEN_CORDW'(speed);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= COOL;
            cool_q    <= CDW'(COOLDOWN_MIN);
            tries_q   <= '0;
            sel_col_q <= '0;
            sel_req_q <= 1'b0;
            gap_q     <= 1'b0;
            bomb_x_q  <= '0;
            bomb_y_q  <= '0;
        end else begin
            state_q   <= state_d;
            cool_q    <= cool_d;
            tries_q   <= tries_d;
            sel_col_q <= sel_col_d;
            sel_req_q <= sel_req_d;
            gap_q     <= gap_d;
            bomb_x_q  <= bomb_x_d;
            bomb_y_q  <= bomb_y_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cool_d    = cool_q;
        tries_d   = tries_q;
        sel_col_d = sel_col_q;
        sel_req_d = sel_req_q;
        gap_d     = gap_q;
        bomb_x_d  = bomb_x_q;
        bomb_y_d  = bomb_y_q;
        case (state_q)
            COOL: begin
                if (frame && en) begin
                    if (cool_q == '0) begin
                        state_d   = SEL;
                        sel_col_d = w_rand_col;
                        sel_req_d = 1'b1;
                        gap_d     = 1'b0;
                        tries_d   = '0;
                    end else begin
                        cool_d = cool_q - 1'b1;
                    end
                end
            end
            SEL: begin
                if (gap_q) begin
                    sel_req_d = 1'b1;
                    gap_d     = 1'b0;
                end else if (sel_req_q && sel_ack) begin
                    sel_req_d = 1'b0;
                    if (sel_hit) begin
                        state_d  = FALL;
                        bomb_x_d = sel_x + SCREEN_CORDW'(SPAWN_DX);
                        bomb_y_d = sel_y + SCREEN_CORDW'(SPAWN_DY);
                    end else begin
                        sel_col_d = w_next_col;
                        tries_d   = tries_q + 1'b1;
                        // Every column has now missed: the grid is empty.
                        if (tries_q == COLW'(N_COLS - 1)) begin
                            state_d = COOL;
                            cool_d  = CDW'(COOLDOWN_MIN);
                        end else begin
                            gap_d = 1'b1;
                        end
                    end
                end
            end
            FALL: begin
                // hit takes priority, so a simultaneous frame does not move the bomb
                if (hit || (frame && (w_ny >= V_LIMIT))) begin
                    state_d = COOL;
                    cool_d  = CDW'(COOLDOWN_MIN) + CDW'(w_lfsr[7:4]);
                end else if (frame) begin
                    bomb_y_d = w_ny;
                end
            end
            default: begin
                state_d = COOL;
            end
        endcase
    end

    // Outputs
    always_comb begin
        w_active    = (state_q == FALL);
        bomb_active = w_active;
        sel_req     = sel_req_q;
        sel_col     = sel_col_q;
        bomb_x      = bomb_x_q;
        bomb_y      = bomb_y_q;
        drawing     = w_spr_drawing & w_active;
        pixel       = w_spr_pix;
    end

    sprite #(
        .CORDW     (SCREEN_CORDW),
        .COLR_BITS (COLR_BITS),
        .H_RES     (H_RES),
        .WIDTH     (BOMB_WIDTH),
        .HEIGHT    (BOMB_HEIGHT),
        .SCALE     (BOMB_SCALE),
        .BITMAP    (BOMB_BITMAP),
        .COLR      (COLR_BITS'(BOMB_COLR))
    ) u_sprite (
        .clk     (clk),
        .rst     (rst),
        .en      (w_active),
        .line    (screen_line),
        .sx      (screen_x),
        .sy      (screen_y),
        .sprx    (bomb_x_q),
        .spry    (bomb_y_q),
        .pix     (w_spr_pix),
        .drawing (w_spr_drawing)
    );

endmodule : alien_bomb
`default_nettype wire
